// File: rtl/eeg_loader_pkg.sv
// eeg_loader_pkg: shared types, constants and the ADC-to-intermediate conversion for the EEG loader.
package eeg_loader_pkg;
   localparam int NUM_PATCHES     = 60;
   localparam int PATCH_LEN       = 64;
   localparam int ADC_BITWIDTH    = 16;
   localparam int EEG_NUM_SAMPLES = NUM_PATCHES * PATCH_LEN;
   localparam int ADC_MIDSCALE    = 1 << (ADC_BITWIDTH - 1);

   typedef logic [ADC_BITWIDTH-1:0]                 AdcData_t;
   typedef logic [15:0]                             IntResAddr_t;
   typedef logic [15:0]                             IntResDouble_t;
   typedef logic [$clog2(EEG_NUM_SAMPLES+1)-1:0]    EegCnt_t;

   typedef enum logic [1:0] {EEG_LD_IDLE, EEG_LD_LOAD, EEG_LD_DRAIN} EegLoaderState_t;
   typedef enum logic {SINGLE_WIDTH, DOUBLE_WIDTH} MemWidth_t;
   typedef enum logic [2:0] {INT_RES_SW_FX, INT_RES_DW_FX} MemFormat_t;

   localparam IntResAddr_t EEG_INPUT_MEM_BASE = 16'h0000;

   // Centring in 16 bits is a plain wrap-around subtract; the shift then keeps the sign.
   function automatic IntResDouble_t adc_to_word(input AdcData_t d, input int unsigned shift);
      return IntResDouble_t'($signed(d - AdcData_t'(ADC_MIDSCALE)) >>> shift);
   endfunction
endpackage

// File: rtl/eeg_skid_fifo.sv
// eeg_skid_fifo: two-entry FIFO of converted words between the ADC accept and the memory write port.
module eeg_skid_fifo
   import eeg_loader_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  IntResDouble_t din,
   input  logic          pop,
   output IntResDouble_t dout,
   output logic          full,
   output logic          empty
);
   IntResDouble_t mem [2];
   logic [1:0]    cnt;
   logic          wp, rp;

   assign dout  = mem[rp];
   assign full  = cnt == 2'd2;
   assign empty = cnt == 2'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         cnt    <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
      end else begin
         if (push) mem[wp] <= din;
         wp  <= wp ^ push;
         rp  <= rp ^ pop;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/eeg_loader.sv
// eeg_loader: streams one EEG epoch from the ADC into intermediate-result memory,
// centring each sample and writing it to consecutive addresses from BASE_ADDR.
module eeg_loader
   import eeg_loader_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = EEG_NUM_SAMPLES,
   parameter IntResAddr_t BASE_ADDR   = EEG_INPUT_MEM_BASE,
   parameter int unsigned ADC_SHIFT   = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          adc_valid,
   input  AdcData_t      adc_data,
   output logic          adc_ready,
   output logic          mem_wr_req,
   output IntResAddr_t   mem_wr_addr,
   output IntResDouble_t mem_wr_data,
   output logic          mem_wr_width,
   output logic [2:0]    mem_wr_format,
   input  logic          mem_wr_gnt,
   output logic          busy,
   output logic          done,
   output logic          err_stray
);
   EegLoaderState_t state, state_nxt;
   EegCnt_t         accept_cnt, write_cnt;
   logic            full, empty, push, pop, done_nxt, last_in, last_out;

   assign last_in       = accept_cnt == EegCnt_t'(NUM_SAMPLES - 1);
   assign last_out      = write_cnt == EegCnt_t'(NUM_SAMPLES - 1);
   assign adc_ready     = (state == EEG_LD_LOAD) && !full && (accept_cnt < EegCnt_t'(NUM_SAMPLES));
   assign push          = adc_valid && adc_ready;
   assign pop           = mem_wr_req && mem_wr_gnt;
   assign mem_wr_req    = !empty;
   assign mem_wr_addr   = BASE_ADDR + IntResAddr_t'(write_cnt);
   assign mem_wr_width  = DOUBLE_WIDTH;
   assign mem_wr_format = INT_RES_DW_FX;
   assign busy          = state != EEG_LD_IDLE;

   eeg_skid_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (adc_to_word(adc_data, ADC_SHIFT)),
      .pop   (pop),
      .dout  (mem_wr_data),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         EEG_LD_IDLE:  state_nxt = start ? EEG_LD_LOAD : EEG_LD_IDLE;
         EEG_LD_LOAD:  state_nxt = (push && last_in) ? EEG_LD_DRAIN : EEG_LD_LOAD;
         EEG_LD_DRAIN: begin
            done_nxt  = pop && last_out;
            state_nxt = done_nxt ? EEG_LD_IDLE : EEG_LD_DRAIN;
         end
         default:      state_nxt = EEG_LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EEG_LD_IDLE;
         accept_cnt <= '0;
         write_cnt  <= '0;
         done       <= 1'b0;
         err_stray  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (state == EEG_LD_IDLE && start) begin
            accept_cnt <= '0;
            write_cnt  <= '0;
            err_stray  <= 1'b0;
         end else begin
            accept_cnt <= accept_cnt + EegCnt_t'(push);
            write_cnt  <= write_cnt + EegCnt_t'(pop);
            if (state == EEG_LD_IDLE && adc_valid) err_stray <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_eeg_loader.sv
// tb_eeg_loader: directed epochs checked every cycle against a queue-based model of the loader.
module tb_eeg_loader;
   import eeg_loader_pkg::*;

   localparam int NUM = 3840;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, adc_valid = 1'b0, mem_wr_gnt = 1'b0;
   logic [15:0] adc_data = '0;
   logic        adc_ready, mem_wr_req, mem_wr_width, busy, done, err_stray;
   logic [15:0] mem_wr_addr, mem_wr_data;
   logic [2:0]  mem_wr_format;
   logic        d2_ready, d2_req, d2_width, d2_busy, d2_done, d2_err;
   logic [15:0] d2_addr, d2_data;
   logic [2:0]  d2_format;

   always #5 clk = ~clk;

   eeg_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
      .adc_ready(adc_ready), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_width(mem_wr_width), .mem_wr_format(mem_wr_format),
      .mem_wr_gnt(mem_wr_gnt), .busy(busy), .done(done), .err_stray(err_stray)
   );

   eeg_loader #(.ADC_SHIFT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
      .adc_ready(d2_ready), .mem_wr_req(d2_req), .mem_wr_addr(d2_addr),
      .mem_wr_data(d2_data), .mem_wr_width(d2_width), .mem_wr_format(d2_format),
      .mem_wr_gnt(mem_wr_gnt), .busy(d2_busy), .done(d2_done), .err_stray(d2_err)
   );

   int n_vec = 0, n_err = 0;
   int mode = 0, grants = 0, done_cnt = 0, full_seen = 0, first_addr = -1;
   logic [15:0] img [4096];
   logic [15:0] img2 [4096];
   bit en = 0;

   // Model: words waiting for memory, counts of accepted and written samples.
   logic [15:0] q[$], q2[$];
   bit m_active = 0, m_loading = 0, m_err = 0, m_done = 0;
   int m_acc = 0, m_wr = 0;

   function automatic logic [15:0] conv(input logic [15:0] d, input int sh);
      int v;
      v = int'(d) - 32768;
      return 16'(v >>> sh);
   endfunction

   function automatic logic [15:0] pat(input int i);
      logic [15:0] b [3];
      b = '{16'h0000, 16'h8000, 16'hFFFF};
      return mode == 0 ? 16'(i) : (i < 3 ? b[i] : 16'(i * 37 + 5));
   endfunction

   function automatic bit m_ready();
      return m_loading && q.size() < 2 && m_acc < NUM;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      bit was_idle, rdy, psh, pp;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         q.delete(); q2.delete();
         m_active = 0; m_loading = 0; m_err = 0; m_done = 0; m_acc = 0; m_wr = 0;
      end else begin
         was_idle = !m_active;
         rdy = m_ready();
         psh = adc_valid && rdy;
         pp  = q.size() > 0 && mem_wr_gnt;
         m_done = pp && m_wr == NUM - 1;
         if (pp) begin
            void'(q.pop_front()); void'(q2.pop_front()); m_wr++;
         end
         if (psh) begin
            q.push_back(conv(adc_data, 0)); q2.push_back(conv(adc_data, 2)); m_acc++;
            if (m_acc == NUM) m_loading = 0;
         end
         if (m_done) m_active = 0;
         if (was_idle) begin
            if (start) begin
               m_err = 0; m_active = 1; m_loading = 1; m_acc = 0; m_wr = 0;
            end else if (adc_valid) m_err = 1;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      if (rst_n && mem_wr_req && mem_wr_gnt) begin
         if (grants == 0) first_addr = int'(mem_wr_addr);
         img[mem_wr_addr[11:0]]  = mem_wr_data;
         img2[mem_wr_addr[11:0]] = d2_data;
         grants++;
      end
   end

   initial begin
      bit p_req, p_gnt;
      logic [15:0] p_addr, p_data;
      p_req = 0; p_gnt = 0; p_addr = '0; p_data = '0;
      forever begin
         @(negedge clk);
         if (en) begin
            chk("adc_ready", 32'(adc_ready), 32'(m_ready()));
            chk("mem_wr_req", 32'(mem_wr_req), 32'(q.size() != 0));
            chk("req_shift2", 32'(d2_req), 32'(q.size() != 0));
            if (q.size() != 0) begin
               chk("mem_wr_addr", 32'(mem_wr_addr), 32'(m_wr));
               chk("mem_wr_data", 32'(mem_wr_data), 32'(q[0]));
               chk("data_shift2", 32'(d2_data), 32'(q2[0]));
            end
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("err_stray", 32'(err_stray), 32'(m_err));
            chk("mem_wr_width", 32'(mem_wr_width), 32'(1));
            chk("mem_wr_format", 32'(mem_wr_format), 32'(INT_RES_DW_FX));
            if (rst_n && p_req && !p_gnt) begin
               chk("hold_req", 32'(mem_wr_req), 32'(1));
               chk("hold_addr", 32'(mem_wr_addr), 32'(p_addr));
               chk("hold_data", 32'(mem_wr_data), 32'(p_data));
            end
            if (rst_n && done) done_cnt++;
            if (rst_n && mem_wr_req && !adc_ready && m_loading) full_seen++;
            p_req = rst_n && mem_wr_req; p_gnt = mem_wr_gnt;
            p_addr = mem_wr_addr; p_data = mem_wr_data;
         end
      end
   end

   task automatic drive(input logic v, input logic g, input logic s);
      @(posedge clk);
      #1;
      adc_valid = v; mem_wr_gnt = g; start = s; adc_data = pat(m_acc);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(adc_ready), 0);
      chk({tag, "_req"},   32'(mem_wr_req), 0);
      chk({tag, "_addr"},  32'(mem_wr_addr), 0);
      chk({tag, "_data"},  32'(mem_wr_data), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_err"},   32'(err_stray), 0);
   endtask

   task automatic epoch(input bit bp, input int stall_at, input int mid_start, output int cyc);
      grants = 0; done_cnt = 0; first_addr = -1; cyc = -1;
      drive(0, 1, 1);
      for (int n = 1; n <= 20000; n++) begin
         drive(!(stall_at > 0 && n >= stall_at && n < stall_at + 50), bp ? (n % 3 == 0) : 1'b1, n == mid_start);
         if (n == 1) chk("err_cleared_by_start", 32'(err_stray), 0);
         if (stall_at > 0 && n == stall_at + 49) chk("stall_req_low", 32'(mem_wr_req), 0);
         if (done) begin
            cyc = n - 1;
            break;
         end
      end
      drive(0, 1, 0);
      drive(0, 1, 0);
      chk("epoch_done_seen", 32'(cyc >= 0), 1);
      chk("done_count", 32'(done_cnt), 1);
      chk("write_count", 32'(grants), NUM);
      chk("first_addr", 32'(first_addr), 0);
      chk("idle_after_done", 32'(busy), 0);
   endtask

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      en = 1;
      // Full epoch, grant always high, data = index.
      mode = 0;
      epoch(0, 0, 0, c);
      chk("epoch_latency_ok", 32'(c >= 3840 && c <= 3842), 1);
      chk("img_first", 32'(img[0]), 32'h8000);
      chk("img_last", 32'(img[3839]), 32'h8EFF);
      chk("img_mid", 32'(img[1000]), 32'h83E8);
      // Backpressure with boundary samples up front.
      mode = 1;
      full_seen = 0;
      epoch(1, 0, 0, c);
      chk("bp_ready_low_seen", 32'(full_seen > 0), 1);
      chk("conv_0000", 32'(img[0]), 32'h8000);
      chk("conv_8000", 32'(img[1]), 32'h0000);
      chk("conv_ffff", 32'(img[2]), 32'h7FFF);
      chk("conv_sh2_0000", 32'(img2[0]), 32'hE000);
      chk("conv_sh2_ffff", 32'(img2[2]), 32'h1FFF);
      // Stray valid in idle, then a start mid-load that must be ignored.
      mode = 0;
      repeat (3) drive(1, 1, 0);
      drive(0, 1, 0);
      chk("stray_err_set", 32'(err_stray), 1);
      chk("stray_no_req", 32'(mem_wr_req), 0);
      epoch(0, 0, 500, c);
      chk("img_last_restart", 32'(img[3839]), 32'h8EFF);
      // Reset after 100 writes, then a stalled epoch from address 0.
      grants = 0;
      drive(0, 1, 1);
      for (int n = 0; n < 1000 && grants < 100; n++) drive(1, 1, 0);
      chk("reached_100_writes", 32'(grants >= 100), 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      drive(0, 1, 0);
      drive(0, 1, 0);
      rst_n = 1'b1;
      epoch(0, 1000, 0, c);
      chk("stall_latency_ok", 32'(c >= 3890 && c <= 3892), 1);
      chk("img_last_stall", 32'(img[3839]), 32'h8EFF);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
